// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: four-master round-robin bus arbiter with a registered one-hot grant.
// The search starts one past the most recently granted master. The owner holds the
// grant while its request stays high. When the owner drops its request, the grant is
// handed to the next requester with no idle cycle in between.
// Optional feature macro: BUS_ARB_BURST_LIMIT_EN. When it is defined, an owner that has
// held the grant for MAX_BURST cycles is forced to yield if another master is waiting,
// and burst_cnt saturates at MAX_BURST-1 instead of 15.
module bus_rr_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic [1:0] grant_id,
  output logic [3:0] burst_cnt
);

`ifdef BUS_ARB_BURST_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  // Saturation point of the tenure counter; it is also the rotation point when the limit is enabled.
  localparam logic [3:0] BURST_SAT = LIMIT_EN ? 4'(MAX_BURST - 1) : 4'd15;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_r;
  logic [1:0] last_r;
  logic [2:0] pick_all_s;    // {found, index} over every requester
  logic [2:0] pick_other_s;  // {found, index} over requesters other than the owner
  logic       owner_req_s;
  logic       rotate_s;

  // Finds the first set bit of cand in the order last+1, last+2, last+3, last (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!res[2] && cand[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Converts a master index into a one-hot grant vector.
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Next-owner selection and the forced-rotation condition.
  always_comb begin
    pick_all_s   = rr_pick(req, last_r);
    pick_other_s = rr_pick(req & ~grant, last_r);
    owner_req_s  = |(req & grant);
    rotate_s     = 1'b0;
    if (LIMIT_EN) begin
      rotate_s = owner_req_s && (burst_cnt == BURST_SAT) && pick_other_s[2];
    end else begin
      rotate_s = 1'b0;
    end
  end

  // Arbitration state machine. It updates the registered grant, the owner index, the tenure counter and the pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      grant       <= 4'b0000;
      grant_valid <= 1'b0;
      grant_id    <= 2'd0;
      burst_cnt   <= 4'd0;
      last_r      <= 2'd3;
    end else begin
      case (state_r)
        IDLE: begin
          if (pick_all_s[2]) begin
            state_r     <= BUSY;
            grant       <= onehot(pick_all_s[1:0]);
            grant_valid <= 1'b1;
            grant_id    <= pick_all_s[1:0];
            last_r      <= pick_all_s[1:0];
            burst_cnt   <= 4'd0;
          end else begin
            grant       <= 4'b0000;
            grant_valid <= 1'b0;
            burst_cnt   <= 4'd0;
          end
        end
        BUSY: begin
          if (owner_req_s && !rotate_s) begin
            // Owner keeps the bus; count its tenure up to the saturation point.
            if (burst_cnt != BURST_SAT) begin
              burst_cnt <= burst_cnt + 4'd1;
            end else begin
              burst_cnt <= burst_cnt;
            end
          end else if (pick_other_s[2]) begin
            // Zero-bubble handover, either after a release or after a forced rotation.
            grant       <= onehot(pick_other_s[1:0]);
            grant_valid <= 1'b1;
            grant_id    <= pick_other_s[1:0];
            last_r      <= pick_other_s[1:0];
            burst_cnt   <= 4'd0;
          end else begin
            // Nobody wants the bus. grant_id and last_r keep the old owner.
            state_r     <= IDLE;
            grant       <= 4'b0000;
            grant_valid <= 1'b0;
            burst_cnt   <= 4'd0;
          end
        end
        default: begin
          state_r     <= IDLE;
          grant       <= 4'b0000;
          grant_valid <= 1'b0;
          burst_cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter. Each call to drive() pushes the expected
// outputs for the next cycle onto a queue. Each test task pops one entry after the
// clock edge and compares it with the DUT outputs.
// Expectations follow BUS_ARB_BURST_LIMIT_EN, so the bench suits either build.
module tb_bus_rr_arbiter;

  localparam int MAXB = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] burst_cnt;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic [3:0] b;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_id_hold = 2'd0;

  bus_rr_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .burst_cnt   (burst_cnt)
  );

  always #5 clk = ~clk;

`ifdef BUS_ARB_BURST_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  // Drives a request pattern and queues the outputs expected after the next rising edge.
  // While idle, grant_id is expected to keep the last owner.
  task automatic drive(input logic [3:0] r, input logic [3:0] eg, input logic [3:0] eb);
    exp_t e;
    req  = r;
    e.g  = eg;
    e.b  = eb;
    e.id = exp_id_hold;
    for (int i = 0; i < 4; i++) begin
      if (eg[i]) e.id = 2'(i);
    end
    exp_id_hold = e.id;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({grant, grant_valid, grant_id, burst_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL reset: grant=%b valid=%b id=%0d burst=%0d, required all zero",
               grant, grant_valid, grant_id, burst_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_first_grant();
    exp_t e;
    drive(4'b1111, 4'b0001, 4'd0);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    checks++;
    if ({grant, grant_valid, grant_id, burst_cnt} !== {e.g, |e.g, e.id, e.b}) begin
      errors++;
      $display("FAIL first_grant: grant=%b valid=%b id=%0d burst=%0d, required %b %b %0d %0d",
               grant, grant_valid, grant_id, burst_cnt, e.g, |e.g, e.id, e.b);
    end
  endtask

  // Each owner drops its request for one cycle. The grant order is 0,1,2,3,0. Then the bus idles, and the pointer must resume after master 0.
  task automatic test_round_robin();
    exp_t e;
    logic [3:0] rq [10] = '{4'b1110, 4'b1111, 4'b1101, 4'b1111, 4'b1011,
                            4'b1111, 4'b0111, 4'b0000, 4'b1111, 4'b0000};
    logic [3:0] eg [10] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000,
                            4'b1000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
    logic [3:0] eb [10] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    for (int i = 0; i < 10; i++) begin
      drive(rq[i], eg[i], eb[i]);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({grant, grant_valid, grant_id, burst_cnt} !== {e.g, |e.g, e.id, e.b}) begin
        errors++;
        $display("FAIL round_robin[%0d]: grant=%b valid=%b id=%0d burst=%0d, required %b %b %0d %0d",
                 i, grant, grant_valid, grant_id, burst_cnt, e.g, |e.g, e.id, e.b);
      end
    end
  endtask

  // The owner releases while two new requests arrive in the same cycle. The search order picks master 1 over master 3.
  task automatic test_simultaneous();
    exp_t e;
    logic [3:0] rq [3] = '{4'b0001, 4'b1010, 4'b0000};
    logic [3:0] eg [3] = '{4'b0001, 4'b0010, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      drive(rq[i], eg[i], 4'd0);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({grant, grant_valid, grant_id, burst_cnt} !== {e.g, |e.g, e.id, e.b}) begin
        errors++;
        $display("FAIL simultaneous[%0d]: grant=%b valid=%b id=%0d burst=%0d, required %b %b %0d %0d",
                 i, grant, grant_valid, grant_id, burst_cnt, e.g, |e.g, e.id, e.b);
      end
    end
  endtask

  // req=0011 is held. With the limit, the grant alternates every MAXB cycles. Without it, master 0 keeps the grant and the counter saturates at 15.
  task automatic test_burst();
    exp_t e;
    int n;
    logic [3:0] g;
    n = LIMIT_EN ? 12 : 20;
    for (int i = 0; i < n; i++) begin
      if (LIMIT_EN) begin
        g = ((i / MAXB) % 2 == 0) ? 4'b0001 : 4'b0010;
        drive(4'b0011, g, 4'(i % MAXB));
      end else begin
        drive(4'b0011, 4'b0001, (i > 15) ? 4'd15 : 4'(i));
      end
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({grant, grant_valid, grant_id, burst_cnt} !== {e.g, |e.g, e.id, e.b}) begin
        errors++;
        $display("FAIL burst[%0d]: grant=%b valid=%b id=%0d burst=%0d, required %b %b %0d %0d",
                 i, grant, grant_valid, grant_id, burst_cnt, e.g, |e.g, e.id, e.b);
      end
    end
    drive(4'b0000, 4'b0000, 4'd0);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    checks++;
    if ({grant, grant_valid, grant_id, burst_cnt} !== {e.g, |e.g, e.id, e.b}) begin
      errors++;
      $display("FAIL burst_release: grant=%b valid=%b id=%0d burst=%0d, required %b %b %0d %0d",
               grant, grant_valid, grant_id, burst_cnt, e.g, |e.g, e.id, e.b);
    end
  endtask

  // A lone requester keeps the bus for 20 cycles. burst_cnt saturates at MAXB-1 with the limit and at 15 without it.
  task automatic test_lone_requester();
    exp_t e;
    int sat;
    sat = LIMIT_EN ? MAXB - 1 : 15;
    for (int i = 0; i < 20; i++) begin
      drive(4'b0100, 4'b0100, (i > sat) ? 4'(sat) : 4'(i));
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if ({grant, grant_valid, grant_id, burst_cnt} !== {e.g, |e.g, e.id, e.b}) begin
        errors++;
        $display("FAIL lone[%0d]: grant=%b valid=%b id=%0d burst=%0d, required %b %b %0d %0d",
                 i, grant, grant_valid, grant_id, burst_cnt, e.g, |e.g, e.id, e.b);
      end
    end
  endtask

  // Reset is asserted between edges while master 2 owns the bus. Afterwards, master 0 has first priority, so req=0110 goes to master 1.
  task automatic test_async_reset();
    exp_t e;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({grant, grant_valid, grant_id, burst_cnt} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: grant=%b valid=%b id=%0d burst=%0d, required all zero before next edge",
               grant, grant_valid, grant_id, burst_cnt);
    end
    req = 4'b0000;
    sb_q.delete();
    exp_id_hold = 2'd0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(4'b0110, 4'b0010, 4'd0);
    drive(4'b0000, 4'b0000, 4'd0);
    // The first queued entry needs req=0110 and the second req=0000, so req is applied per cycle.
    req = 4'b0110;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL post_reset[%0d]: scoreboard empty, required an entry", i);
      end else begin
        e = sb_q.pop_front();
        if ({grant, grant_valid, grant_id, burst_cnt} !== {e.g, |e.g, e.id, e.b}) begin
          errors++;
          $display("FAIL post_reset[%0d]: grant=%b valid=%b id=%0d burst=%0d, required %b %b %0d %0d",
                   i, grant, grant_valid, grant_id, burst_cnt, e.g, |e.g, e.id, e.b);
        end
      end
      req = 4'b0000;
      if (i == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_round_robin();
    test_simultaneous();
    test_burst();
    test_lone_requester();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
